// File: rtl/invader_march_if.sv
// Bundle between the tick/game-control side and the formation motion controller.
interface invader_march_if;
  logic       tick;
  logic       en;
  logic       restart;
  logic [3:0] div;
  logic [9:0] posX;
  logic [9:0] posY;
  logic       dir;
  logic       step;
  logic       landed;

  modport master (
    output tick, en, restart, div,
    input  posX, posY, dir, step, landed
  );

  modport slave (
    input  tick, en, restart, div,
    output posX, posY, dir, step, landed
  );
endinterface

// File: rtl/invader_march.sv
// Formation motion controller: divides tick pulses into march steps and walks
// the invader origin right/left, dropping a row and reversing at each edge.
module invader_march #(
  parameter int unsigned X_START = 32,
  parameter int unsigned Y_START = 40,
  parameter int unsigned X_MIN   = 16,
  parameter int unsigned X_MAX   = 560,
  parameter int unsigned X_STEP  = 8,
  parameter int unsigned Y_STEP  = 16,
  parameter int unsigned Y_LIMIT = 400
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  invader_march_if.slave bus
);

  typedef enum logic [1:0] {
    MARCH_R,
    MARCH_L,
    LANDED
  } state_e;

  localparam logic [9:0]  XStart     = 10'(X_START);
  localparam logic [9:0]  YStart     = 10'(Y_START);
  localparam logic [9:0]  XStep10    = 10'(X_STEP);
  localparam logic [10:0] XStep11    = 11'(X_STEP);
  localparam logic [10:0] YStep11    = 11'(Y_STEP);
  localparam logic [10:0] XMax11     = 11'(X_MAX);
  localparam logic [10:0] XLeftLim11 = 11'(X_MIN + X_STEP);
  localparam logic [10:0] YLimit11   = 11'(Y_LIMIT);

  state_e     state_q, state_d;
  logic [9:0] posX_q, posX_d;
  logic [9:0] posY_q, posY_d;
  logic       dir_q, dir_d;
  logic       step_q, step_d;
  logic [3:0] tc_q, tc_d;

  logic        qualTick;
  logic        stepFire;
  logic [10:0] rightSum;
  logic [10:0] downSum;
  logic        atRightEdge;
  logic        atLeftEdge;
  logic        willLand;

  // Edge and landing decisions use 11-bit sums so a 10-bit position never wraps.
  assign qualTick    = bus.tick & bus.en & (state_q != LANDED);
  assign stepFire    = qualTick & (tc_q >= bus.div);
  assign rightSum    = {1'b0, posX_q} + XStep11;
  assign downSum     = {1'b0, posY_q} + YStep11;
  assign atRightEdge = rightSum > XMax11;
  assign atLeftEdge  = {1'b0, posX_q} < XLeftLim11;
  assign willLand    = downSum >= YLimit11;

  always_comb begin
    tc_d = tc_q;
    if (bus.restart) begin
      tc_d = '0;
    end else if (qualTick) begin
      tc_d = stepFire ? 4'd0 : tc_q + 4'd1;
    end
  end

  // A landing drop keeps the pre-drop direction so the renderer sees it frozen.
  always_comb begin
    state_d = state_q;
    posX_d  = posX_q;
    posY_d  = posY_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    if (bus.restart) begin
      state_d = MARCH_R;
      posX_d  = XStart;
      posY_d  = YStart;
      dir_d   = 1'b1;
    end else if (stepFire) begin
      step_d = 1'b1;
      case (state_q)
        MARCH_R: begin
          if (atRightEdge) begin
            posY_d  = downSum[9:0];
            state_d = willLand ? LANDED : MARCH_L;
            dir_d   = willLand ? dir_q : 1'b0;
          end else begin
            posX_d = rightSum[9:0];
          end
        end
        MARCH_L: begin
          if (atLeftEdge) begin
            posY_d  = downSum[9:0];
            state_d = willLand ? LANDED : MARCH_R;
            dir_d   = willLand ? dir_q : 1'b1;
          end else begin
            posX_d = posX_q - XStep10;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MARCH_R;
      posX_q  <= XStart;
      posY_q  <= YStart;
      dir_q   <= 1'b1;
      step_q  <= 1'b0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      posX_q  <= posX_d;
      posY_q  <= posY_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.posX   = posX_q;
  assign bus.posY   = posY_q;
  assign bus.dir    = dir_q;
  assign bus.step   = step_q;
  assign bus.landed = (state_q == LANDED);

endmodule

// File: tb/tb_invader_march.sv
// Randomized and directed bench for invader_march against a plain-arithmetic
// model of the formation's march, drop and landing rules.
module tb_invader_march;

  logic clk = 1'b0;
  logic rstN;
  int   assertCount = 0;
  int   failCount   = 0;
  bit   compareOn   = 1'b0;

  invader_march_if bus ();

  invader_march dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int mX = 32;
  int mY = 40;
  int mTc = 0;
  bit mDir = 1'b1;
  bit mStep = 1'b0;
  bit mLanded = 1'b0;

  function automatic void modelReset();
    mX = 32; mY = 40; mTc = 0;
    mDir = 1'b1; mStep = 1'b0; mLanded = 1'b0;
  endfunction

  function automatic void modelStep();
    bit drop;
    mStep = 1'b1;
    drop = 1'b0;
    if (mDir) begin
      if (mX + 8 > 560) drop = 1'b1;
      else mX = mX + 8;
    end else begin
      if (mX < 16 + 8) drop = 1'b1;
      else mX = mX - 8;
    end
    if (drop) begin
      mY = mY + 16;
      if (mY >= 400) mLanded = 1'b1;
      else mDir = !mDir;
    end
  endfunction

  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      modelReset();
    end else begin
      mStep = 1'b0;
      if (bus.restart) begin
        modelReset();
      end else if (bus.tick && bus.en && !mLanded) begin
        if (mTc >= int'(bus.div)) begin
          mTc = 0;
          modelStep();
        end else begin
          mTc = mTc + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (compareOn) begin
      assertCount++;
      if (int'(bus.posX) != mX || int'(bus.posY) != mY || bus.dir !== mDir ||
          bus.step !== mStep || bus.landed !== mLanded) begin
        failCount++;
        $display("[TB] FAIL cycleCompare t=%0t actual X=%0d Y=%0d dir=%0b step=%0b landed=%0b expected X=%0d Y=%0d dir=%0b step=%0b landed=%0b",
                 $time, bus.posX, bus.posY, bus.dir, bus.step, bus.landed,
                 mX, mY, mDir, mStep, mLanded);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assertCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit en, input bit restart, input int div);
    bus.tick    = tick;
    bus.en      = en;
    bus.restart = restart;
    bus.div     = 4'(div);
    @(posedge clk);
    #1;
  endtask

  task automatic stepOnce();
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic finishRun();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  endtask

  initial begin
    #1_000_000;
    failCount++;
    $display("[TB] FAIL watchdog: actual timeout, expected completion");
    finishRun();
  end

  initial begin
    bit t, e, r, prevTick;
    int n;
    rstN        = 1'b0;
    bus.tick    = 1'b0;
    bus.en      = 1'b0;
    bus.restart = 1'b0;
    bus.div     = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    compareOn = 1'b1;
    checkOutput("resetPosX", bus.posX, 32);
    checkOutput("resetPosY", bus.posY, 40);
    checkOutput("resetDir", bus.dir, 1);
    checkOutput("resetStep", bus.step, 0);
    checkOutput("resetLanded", bus.landed, 0);
    rstN = 1'b1;

    repeat (4) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0);
    end
    checkOutput("enLowPosX", bus.posX, 32);

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      checkOutput("div0Step", bus.step, 1);
      checkOutput("div0PosX", bus.posX, 32 + 8 * i);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      checkOutput("div0StepLow", bus.step, 0);
    end
    checkOutput("div0PosY", bus.posY, 40);

    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 2);
      checkOutput("div2Step", bus.step, (i == 3) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 2);
    end
    checkOutput("div2PosX", bus.posX, 64);

    repeat (2) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 5);
      checkOutput("divShrinkWait", bus.step, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 5);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    checkOutput("divShrinkStep", bus.step, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);

    prevTick = 1'b0;
    for (int i = 0; i < 600; i++) begin
      t = !prevTick && ($urandom_range(0, 1) == 1);
      e = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 59) == 0);
      applyStimulus(t, e, r, int'($urandom_range(0, 3)));
      prevTick = t;
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    n = 0;
    while (!(bus.posX == 10'd560 && bus.dir) && n < 200) begin
      stepOnce();
      n++;
    end
    checkOutput("rightEdgeX", bus.posX, 560);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    checkOutput("rightDropStep", bus.step, 1);
    checkOutput("rightDropY", bus.posY, 56);
    checkOutput("rightDropX", bus.posX, 560);
    checkOutput("rightDropDir", bus.dir, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    stepOnce();
    checkOutput("rightAfterX", bus.posX, 552);

    n = 0;
    while (!(bus.posX == 10'd16 && !bus.dir) && n < 200) begin
      stepOnce();
      n++;
    end
    checkOutput("leftEdgeX", bus.posX, 16);
    applyStimulus(1'b1, 1'b1, 1'b0, 0);
    checkOutput("leftDropY", bus.posY, 72);
    checkOutput("leftDropDir", bus.dir, 1);
    checkOutput("leftDropX", bus.posX, 16);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    stepOnce();
    checkOutput("leftAfterX", bus.posX, 24);

    n = 0;
    while (!bus.landed && n < 3000) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      n++;
      if (!bus.landed) applyStimulus(1'b0, 1'b1, 1'b0, 0);
    end
    checkOutput("landLanded", bus.landed, 1);
    checkOutput("landStep", bus.step, 1);
    checkOutput("landPosY", bus.posY, 408);
    checkOutput("landPosX", bus.posX, 560);
    checkOutput("landDir", bus.dir, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    repeat (4) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 0);
      checkOutput("landedNoStep", bus.step, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
    end
    checkOutput("landedHoldY", bus.posY, 408);

    applyStimulus(1'b1, 1'b1, 1'b1, 0);
    checkOutput("restartPosX", bus.posX, 32);
    checkOutput("restartPosY", bus.posY, 40);
    checkOutput("restartStep", bus.step, 0);
    checkOutput("restartLanded", bus.landed, 0);
    checkOutput("restartDir", bus.dir, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);

    repeat (3) stepOnce();
    checkOutput("preResetX", bus.posX, 56);
    repeat (2) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
    end
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("asyncResetX", bus.posX, 32);
    checkOutput("asyncResetY", bus.posY, 40);
    checkOutput("asyncResetDir", bus.dir, 1);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      checkOutput("postResetStep", bus.step, (i == 4) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
    end
    checkOutput("postResetX", bus.posX, 40);

    repeat (2) @(posedge clk);
    #1;
    finishRun();
  end

endmodule

// File: doc/invader_march.md
# invader_march

Formation motion controller for the invader grid. It consumes the one-cycle tick pulse from the periodic tick counter and advances the formation origin. The formation marches horizontally in fixed steps, drops one row and reverses at each playfield edge, and flags a landing when it reaches the defender line. Its outputs feed the sprite renderer and the game-state logic.

## Interface
- X_START, 32: formation origin X after reset or restart
- Y_START, 40: formation origin Y after reset or restart
- X_MIN, 16: leftmost legal origin X
- X_MAX, 560: rightmost legal origin X
- X_STEP, 8: horizontal pixels per step
- Y_STEP, 16: vertical pixels per drop
- Y_LIMIT, 400: landing threshold on origin Y
- CLK  in  1  system clock; all state changes on its rising edge
- Rst  in  1  reset; asynchronous, active-low
- M  in  1  tick pulse from the tick counter, high for exactly one CLK cycle
- En  in  1  march enable; while 0, M is ignored and all state holds
- Restart  in  1  synchronous return to the start position
- Div  in  4  a step occurs every Div+1 qualified ticks
- PosX  out  10  formation origin X
- PosY  out  10  formation origin Y
- Dir  out  1  current direction: 1 = right, 0 = left
- Step  out  1  one-cycle strobe that marks a position update
- Landed  out  1  high once the formation has reached Y_LIMIT

## Operation
- The block keeps a 4-bit tick counter `tc`.
- A qualified tick is M=1 with En=1, while the block is not in LANDED.
- On a qualified tick:
  - If tc >= Div, a step event fires and tc clears to 0.
  - Otherwise tc increments by 1.
- The >= compare handles a Div that shrinks mid-count: the next qualified tick steps.
- States: MARCH_R (Dir=1), MARCH_L (Dir=0), LANDED.
- Step event in MARCH_R:
  - If PosX + X_STEP > X_MAX, drop: PosY += Y_STEP, PosX unchanged, next state MARCH_L.
  - Otherwise PosX += X_STEP.
- Step event in MARCH_L:
  - If PosX < X_MIN + X_STEP, drop: PosY += Y_STEP, PosX unchanged, next state MARCH_R.
  - Otherwise PosX -= X_STEP.
- If a drop produces a new PosY >= Y_LIMIT, the next state is LANDED.
  - Landed goes to 1.
  - PosX, PosY and Dir freeze. Dir keeps the value it held before the drop.
- LANDED is left only by Restart or Rst.
- All edge and landing compares are 11 bits wide, so 10-bit sums cannot wrap.
- Restart (synchronous) has priority over everything except Rst. It sets:
  - PosX = X_START, PosY = Y_START
  - state MARCH_R, tc = 0
  - Step = 0, Landed = 0
- Rst low, asynchronously and at any time, forces the same values as Restart.

## Timing
- Reset values: PosX=X_START, PosY=Y_START, Dir=1, Step=0, Landed=0, tc=0.
- Latency: a qualified M sampled at edge k that fires a step produces, at edge k:
  - Step=1 for exactly the following cycle.
  - Updated PosX/PosY/Dir visible from the same edge.
- Landed rises at the same edge as the landing drop, and Step=1 for that drop.
- Only one step can occur per M pulse, so Step is never high two cycles in a row.
- Restart and M in the same cycle: Restart wins, with no step and Step=0.
- En low: tc holds and pending ticks are not accumulated. En has no effect on Restart.
- Div is sampled on every qualified tick. There is no latching.
- Rst asserted mid-count: tc is lost. After Rst deasserts, the first step needs a full Div+1 qualified ticks.

## Test plan
- Reset: hold Rst=0, then release -> PosX=32, PosY=40, Dir=1, Step=0, Landed=0. Ticks with En=0 -> no change.
- Div=0, En=1, three M pulses -> PosX 40, 48, 56, each with a single-cycle Step one edge after M. PosY stays 40.
- Div=2 -> Step only on every 3rd M. Change Div from 2 to 0 after 2 ticks -> the next tick steps.
- Right edge: drive to PosX=560, then one step -> PosY=56, PosX=560, Dir=0. Next step -> PosX=552.
- Left edge: march left to PosX=16, then one step -> PosY rises by 16, Dir=1. Next step -> PosX=24.
- Landing: continue until drop 23 -> PosY=408, Landed=1. Further M pulses produce no Step. Restart together with M -> start values, no Step. Rst low mid-count -> start values immediately.
